csr_unit: RTL and testbench
===========================

# csr_unit

Machine-mode CSR file and trap sequencer for the RV32I core; it is the responder to the instruction decoder's CSR, ECALL and MRET outputs. It executes CSRRW/RS/RC and their immediate forms, holds mstatus/mtvec/mepc/mcause/mscratch and the cycle/instret counters, and raises a held PC-redirect request on trap entry and return. It sits in the execute stage beside the ALU and drives the fetch unit's redirect port.

## Interface
- MTVEC_RESET, 32'h0000_0100, mtvec reset value; bits [1:0] must be 0.
- clk_i  input  1  clock; all state changes on rising edge
- rst_i  input  1  reset, synchronous, active-high
- valid_i  input  1  instruction in EX retires this cycle
- pc_i  input  32  PC of that instruction
- csr_used_i  input  1  instruction is a CSR op
- csr_op_i  input  3  3'b001 RW, 3'b010 RS, 3'b100 RC; other values are no-op
- csr_imm_i  input  1  immediate form; source is zero-extended csr_src_i
- csr_src_i  input  5  rs1 index or zimm (inst[19:15])
- csr_addr_i  input  12  CSR address
- rs1_i  input  32  rs1 value
- is_ecall_i  input  1  ECALL
- is_mret_i  input  1  MRET
- csr_rdata_o  output  32  old CSR value, written to rd; combinational
- busy_o  output  1  redirect pending; upstream must hold valid_i low
- redirect_valid_o  output  1  PC redirect request
- redirect_pc_o  output  32  redirect target
- redirect_ready_i  input  1  fetch accepts redirect

## Operation
- Accepted = valid_i & ~busy_o. Priority: is_ecall_i > is_mret_i > csr_used_i; valid_i while busy_o is ignored.
- Address map: mstatus 0x300, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mhartid 0xF14 (RO, 0), mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82, cycle/cycleh/instret/instreth 0xC00/0xC80/0xC02/0xC82 (RO).
- Write data: src = csr_imm_i ? {27'b0,csr_src_i} : rs1_i. RW: new=src; RS: old|src; RC: old&~src.
- Write enable: RW always; RS/RC only if csr_src_i != 0 (no write, no RO fault).
- Illegal: unmapped address, or write enabled to RO address. Treated as trap, mcause=2, no CSR write.
- Field masks: mstatus only MIE[3], MPIE[7] writable, MPP[12:11] fixed 2'b11; mtvec, mepc bits [1:0] forced 0.
- ECALL: mepc<=pc_i, mcause<=11, MPIE<=MIE, MIE<=0, target=mtvec. Illegal: same with mcause=2.
- MRET: MIE<=MPIE, MPIE<=1, target=mepc (pre-edge value).
- csr_rdata_o = old value on accepted legal CSR op, else 0.
- FSM: IDLE -> REDIRECT on accepted trap/MRET (target captured into redirect_pc_o). REDIRECT -> IDLE on edge with redirect_ready_i=1. busy_o = redirect_valid_o = (state==REDIRECT).
- mcycle: 64-bit, +1 every cycle incl. busy; wraps to 0. minstret: 64-bit, +1 per accepted non-trapping instruction (MRET counts; ECALL, illegal do not). CSR write to a half overrides that half's increment for that edge; other half unchanged (no carry that edge).

## Timing
- Reset: mstatus=32'h0000_1800, mtvec=MTVEC_RESET, all other CSRs and counters 0, state IDLE, redirect_valid_o=0, redirect_pc_o=0, busy_o=0.
- CSR read: 0-cycle (same cycle as valid_i). Write visible to a read the next cycle.
- Redirect: redirect_valid_o rises 1 cycle after accepted trap/MRET; held with stable redirect_pc_o until accepted; drops cycle after acceptance edge. Minimum REDIRECT dwell 1 cycle.
- Reset in REDIRECT: IDLE and redirect_valid_o=0 the cycle after the reset edge; pending redirect discarded.

## Configuration
- CSR_COUNTERS_EN defined: mcycle/minstret and user shadows implemented as above.
- Undefined: no counter flops; counter addresses read 0, writes to 0xB00/0xB80/0xB02/0xB82 ignored (legal), 0xCxx keep RO fault rule.

## Test plan
- Reset, read 0x300 and 0x305 -> 32'h0000_1800 and 32'h0000_0100.
- CSRRW 0x340 rs1=32'hDEAD_BEEF, then CSRRS 0x340 rs1=32'h0000_0010 -> second csr_rdata_o=32'hDEAD_BEEF, mscratch=32'hDEAD_BEFF; CSRRC with csr_src_i=0 -> no change.
- Set MIE, ECALL at pc_i=32'h0000_0040 -> next cycle redirect_valid_o=1, redirect_pc_o=32'h0000_0100, mepc=0x40, mcause=11, mstatus=32'h0000_1880; hold ready low 3 cycles -> request stable, busy_o high.
- MRET after above -> redirect_pc_o=32'h0000_0040, mstatus=32'h0000_1888.
- CSRRW to 0xC00 at pc_i=32'h80 -> trap, mcause=2, mepc=0x80, no minstret increment; CSRRS 0xC00 csr_src_i=0 -> legal read.
- CSRRW 0xB00 = 32'hFFFF_FFFF, idle 1 cycle -> mcycle=0, mcycleh incremented (with CSR_COUNTERS_EN); assert rst_i during REDIRECT -> redirect_valid_o=0 next cycle.

Source files
------------

// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file and ECALL/MRET/illegal-trap redirect sequencer for the RV32I core.
// Define CSR_COUNTERS_EN to build the 64-bit mcycle/minstret counters and their read-only user shadows.
module csr_unit #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0100
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [31:0] pc_i,
  input  logic        csr_used_i,
  input  logic [2:0]  csr_op_i,
  input  logic        csr_imm_i,
  input  logic [4:0]  csr_src_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] rs1_i,
  input  logic        is_ecall_i,
  input  logic        is_mret_i,
  output logic [31:0] csr_rdata_o,
  output logic        busy_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  input  logic        redirect_ready_i
);
  typedef enum logic {IDLE, REDIRECT} state_t;

  localparam logic [2:0] OP_RW = 3'b001;
  localparam logic [2:0] OP_RS = 3'b010;
  localparam logic [2:0] OP_RC = 3'b100;

  state_t      state;
  logic        mie, mpie;
  logic [31:0] mtvec, mepc, mcause, mscratch;
  logic [31:0] mstatus_value;
  logic [63:0] cycle_view, instret_view;

  logic        accepted, do_ecall, do_mret, do_csr, op_valid;
  logic        write_req, illegal, trap, csr_we;
  logic        mapped, read_only;
  logic [31:0] old_value, src, wdata;

  assign busy_o           = (state == REDIRECT);
  assign redirect_valid_o = busy_o;

  // Only MIE and MPIE are stored; MPP is hard-wired to machine mode.
  assign mstatus_value = {19'b0, 2'b11, 3'b0, mpie, 3'b0, mie, 3'b0};

  assign accepted = valid_i & ~busy_o;
  assign do_ecall = accepted & is_ecall_i;
  assign do_mret  = accepted & ~is_ecall_i & is_mret_i;
  assign do_csr   = accepted & ~is_ecall_i & ~is_mret_i & csr_used_i;
  assign op_valid = (csr_op_i == OP_RW) | (csr_op_i == OP_RS) | (csr_op_i == OP_RC);

  // Set/clear with a zero source is a pure read, so it never faults on a read-only CSR.
  assign write_req = do_csr & op_valid & ((csr_op_i == OP_RW) | (csr_src_i != 5'd0));
  assign illegal   = do_csr & op_valid & (~mapped | (write_req & read_only));
  assign csr_we    = write_req & ~illegal;
  assign trap      = do_ecall | illegal;

  assign src = csr_imm_i ? {27'b0, csr_src_i} : rs1_i;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    mapped    = 1'b1;
    read_only = 1'b0;
    old_value = '0;
    case (csr_addr_i)
      12'h300: old_value = mstatus_value;
      12'h305: old_value = mtvec;
      12'h340: old_value = mscratch;
      12'h341: old_value = mepc;
      12'h342: old_value = mcause;
      12'hF14: read_only = 1'b1;
      12'hB00: old_value = cycle_view[31:0];
      12'hB80: old_value = cycle_view[63:32];
      12'hB02: old_value = instret_view[31:0];
      12'hB82: old_value = instret_view[63:32];
      12'hC00: begin old_value = cycle_view[31:0];    read_only = 1'b1; end
      12'hC80: begin old_value = cycle_view[63:32];   read_only = 1'b1; end
      12'hC02: begin old_value = instret_view[31:0];  read_only = 1'b1; end
      12'hC82: begin old_value = instret_view[63:32]; read_only = 1'b1; end
      default: mapped = 1'b0;
    endcase
  end

  always_comb begin
    wdata = src;
    case (csr_op_i)
      OP_RS:   wdata = old_value | src;
      OP_RC:   wdata = old_value & ~src;
      default: wdata = src;
    endcase
  end

  assign csr_rdata_o = (do_csr & op_valid & ~illegal) ? old_value : 32'h0;

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle, minstret, mcycle_next, minstret_next;

  assign cycle_view   = mcycle;
  assign instret_view = minstret;

  // A write to one half replaces that half's increment and suppresses the carry for that edge.
  always_comb begin
    mcycle_next   = mcycle + 64'd1;
    minstret_next = minstret + {63'b0, accepted & ~trap};
    if (csr_we && csr_addr_i == 12'hB00) mcycle_next = {mcycle[63:32], wdata};
    if (csr_we && csr_addr_i == 12'hB80) mcycle_next = {wdata, mcycle[31:0]};
    if (csr_we && csr_addr_i == 12'hB02) minstret_next = {minstret[63:32], wdata};
    if (csr_we && csr_addr_i == 12'hB82) minstret_next = {wdata, minstret[31:0]};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      mcycle   <= mcycle_next;
      minstret <= minstret_next;
    end
  end
`else
  assign cycle_view   = '0;
  assign instret_view = '0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state         <= IDLE;
      redirect_pc_o <= '0;
      mie           <= 1'b0;
      mpie          <= 1'b0;
      mtvec         <= {MTVEC_RESET[31:2], 2'b00};
      mepc          <= '0;
      mcause        <= '0;
      mscratch      <= '0;
    end else begin
      if (csr_we) begin
        case (csr_addr_i)
          12'h300: begin mie <= wdata[3]; mpie <= wdata[7]; end
          12'h305: mtvec    <= {wdata[31:2], 2'b00};
          12'h340: mscratch <= wdata;
          12'h341: mepc     <= {wdata[31:2], 2'b00};
          12'h342: mcause   <= wdata;
          default: ;
        endcase
      end
      if (trap) begin
        mepc          <= {pc_i[31:2], 2'b00};
        mcause        <= do_ecall ? 32'd11 : 32'd2;
        mpie          <= mie;
        mie           <= 1'b0;
        redirect_pc_o <= mtvec;
        state         <= REDIRECT;
      end else if (do_mret) begin
        mie           <= mpie;
        mpie          <= 1'b1;
        redirect_pc_o <= mepc;
        state         <= REDIRECT;
      end else if (state == REDIRECT && redirect_ready_i) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_csr_unit.sv
// Directed self-checking bench for csr_unit: CSR ops, masks, ECALL/MRET/illegal traps, counters, reset.
module tb_csr_unit;
  localparam logic [2:0] OP_RW = 3'b001;
  localparam logic [2:0] OP_RS = 3'b010;
  localparam logic [2:0] OP_RC = 3'b100;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [31:0] pc_i;
  logic        csr_used_i;
  logic [2:0]  csr_op_i;
  logic        csr_imm_i;
  logic [4:0]  csr_src_i;
  logic [11:0] csr_addr_i;
  logic [31:0] rs1_i;
  logic        is_ecall_i;
  logic        is_mret_i;
  logic [31:0] csr_rdata_o;
  logic        busy_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic        redirect_ready_i;

  int total = 0;
  int bad = 0;

  csr_unit dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .pc_i(pc_i),
    .csr_used_i(csr_used_i), .csr_op_i(csr_op_i), .csr_imm_i(csr_imm_i),
    .csr_src_i(csr_src_i), .csr_addr_i(csr_addr_i), .rs1_i(rs1_i),
    .is_ecall_i(is_ecall_i), .is_mret_i(is_mret_i), .csr_rdata_o(csr_rdata_o),
    .busy_o(busy_o), .redirect_valid_o(redirect_valid_o),
    .redirect_pc_o(redirect_pc_o), .redirect_ready_i(redirect_ready_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    valid_i = 0; csr_used_i = 0; csr_op_i = 0; csr_imm_i = 0; csr_src_i = 0;
    csr_addr_i = 0; rs1_i = 0; is_ecall_i = 0; is_mret_i = 0; pc_i = 0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_csr(input logic [2:0] op, input logic [11:0] addr, input logic imm,
                           input logic [4:0] srcv, input logic [31:0] rs1, input logic [31:0] pc);
    valid_i = 1; csr_used_i = 1; csr_op_i = op; csr_addr_i = addr; csr_imm_i = imm;
    csr_src_i = srcv; rs1_i = rs1; pc_i = pc;
    #1;
  endtask

  task automatic read_csr(input logic [11:0] addr, output logic [31:0] data);
    drive_csr(OP_RS, addr, 1'b0, 5'd0, 32'h0, 32'h0);
    data = csr_rdata_o;
    tick();
    clear_inputs();
  endtask

  task automatic accept_redirect();
    redirect_ready_i = 1;
    tick();
    redirect_ready_i = 0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    clear_inputs();
    redirect_ready_i = 0;
    rst_i = 1;
    repeat (2) tick();
    rst_i = 0;
    total++; if (redirect_valid_o !== 1'b0) begin bad++; $display("FAIL reset_rv: got %b want 0", redirect_valid_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    total++; if (redirect_pc_o !== 32'h0) begin bad++; $display("FAIL reset_rpc: got %h want 0", redirect_pc_o); end
    total++; if (csr_rdata_o !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0", csr_rdata_o); end
    read_csr(12'h300, d);
    total++; if (d !== 32'h0000_1800) begin bad++; $display("FAIL reset_mstatus: got %h want 00001800", d); end
    read_csr(12'h305, d);
    total++; if (d !== 32'h0000_0100) begin bad++; $display("FAIL reset_mtvec: got %h want 00000100", d); end
    read_csr(12'hF14, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_mhartid: got %h want 0", d); end
    read_csr(12'h342, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_mcause: got %h want 0", d); end
  endtask

  task automatic test_csr_ops();
    logic [31:0] d;
    drive_csr(OP_RW, 12'h340, 1'b0, 5'd1, 32'hDEAD_BEEF, 32'h0);
    total++; if (csr_rdata_o !== 32'h0) begin bad++; $display("FAIL rw_old: got %h want 0", csr_rdata_o); end
    tick(); clear_inputs();
    drive_csr(OP_RS, 12'h340, 1'b0, 5'd2, 32'h0000_0010, 32'h0);
    total++; if (csr_rdata_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rs_old: got %h want deadbeef", csr_rdata_o); end
    tick(); clear_inputs();
    read_csr(12'h340, d);
    total++; if (d !== 32'hDEAD_BEFF) begin bad++; $display("FAIL rs_new: got %h want deadbeff", d); end
    drive_csr(OP_RC, 12'h340, 1'b0, 5'd0, 32'hFFFF_FFFF, 32'h0);
    total++; if (csr_rdata_o !== 32'hDEAD_BEFF) begin bad++; $display("FAIL rc0_old: got %h want deadbeff", csr_rdata_o); end
    tick(); clear_inputs();
    read_csr(12'h340, d);
    total++; if (d !== 32'hDEAD_BEFF) begin bad++; $display("FAIL rc0_nochange: got %h want deadbeff", d); end
    drive_csr(OP_RC, 12'h340, 1'b1, 5'h1F, 32'h0, 32'h0);
    tick(); clear_inputs();
    read_csr(12'h340, d);
    total++; if (d !== 32'hDEAD_BEE0) begin bad++; $display("FAIL rci: got %h want deadbee0", d); end
    drive_csr(3'b011, 12'h340, 1'b0, 5'd1, 32'h0, 32'h0);
    total++; if (csr_rdata_o !== 32'h0) begin bad++; $display("FAIL noop_rdata: got %h want 0", csr_rdata_o); end
    tick(); clear_inputs();
    read_csr(12'h340, d);
    total++; if (d !== 32'hDEAD_BEE0) begin bad++; $display("FAIL noop_nochange: got %h want deadbee0", d); end
  endtask

  task automatic test_masks();
    logic [31:0] d;
    drive_csr(OP_RW, 12'h305, 1'b0, 5'd1, 32'h0000_0203, 32'h0); tick(); clear_inputs();
    read_csr(12'h305, d);
    total++; if (d !== 32'h0000_0200) begin bad++; $display("FAIL mtvec_mask: got %h want 00000200", d); end
    drive_csr(OP_RW, 12'h305, 1'b0, 5'd1, 32'h0000_0101, 32'h0); tick(); clear_inputs();
    read_csr(12'h305, d);
    total++; if (d !== 32'h0000_0100) begin bad++; $display("FAIL mtvec_restore: got %h want 00000100", d); end
    drive_csr(OP_RW, 12'h300, 1'b0, 5'd1, 32'hFFFF_FFFF, 32'h0); tick(); clear_inputs();
    read_csr(12'h300, d);
    total++; if (d !== 32'h0000_1888) begin bad++; $display("FAIL mstatus_ones: got %h want 00001888", d); end
    drive_csr(OP_RW, 12'h300, 1'b0, 5'd1, 32'h0, 32'h0); tick(); clear_inputs();
    read_csr(12'h300, d);
    total++; if (d !== 32'h0000_1800) begin bad++; $display("FAIL mstatus_zero: got %h want 00001800", d); end
    drive_csr(OP_RS, 12'h300, 1'b1, 5'd8, 32'h0, 32'h0); tick(); clear_inputs();
    read_csr(12'h300, d);
    total++; if (d !== 32'h0000_1808) begin bad++; $display("FAIL mstatus_mie: got %h want 00001808", d); end
  endtask

  task automatic test_ecall();
    logic [31:0] d;
    valid_i = 1; is_ecall_i = 1; pc_i = 32'h0000_0040; #1;
    total++; if (csr_rdata_o !== 32'h0) begin bad++; $display("FAIL ecall_rdata: got %h want 0", csr_rdata_o); end
    tick(); clear_inputs();
    total++; if (redirect_valid_o !== 1'b1) begin bad++; $display("FAIL ecall_rv: got %b want 1", redirect_valid_o); end
    total++; if (redirect_pc_o !== 32'h0000_0100) begin bad++; $display("FAIL ecall_rpc: got %h want 00000100", redirect_pc_o); end
    for (int i = 0; i < 3; i++) begin
      drive_csr(OP_RW, 12'h340, 1'b0, 5'd1, 32'h0000_1234, 32'h0);
      total++; if (csr_rdata_o !== 32'h0) begin bad++; $display("FAIL busy_rdata%0d: got %h want 0", i, csr_rdata_o); end
      tick(); clear_inputs();
      total++; if (redirect_valid_o !== 1'b1 || busy_o !== 1'b1) begin bad++; $display("FAIL hold_rv%0d: got rv=%b busy=%b want 1/1", i, redirect_valid_o, busy_o); end
      total++; if (redirect_pc_o !== 32'h0000_0100) begin bad++; $display("FAIL hold_rpc%0d: got %h want 00000100", i, redirect_pc_o); end
    end
    accept_redirect();
    total++; if (redirect_valid_o !== 1'b0 || busy_o !== 1'b0) begin bad++; $display("FAIL ecall_drop: got rv=%b busy=%b want 0/0", redirect_valid_o, busy_o); end
    read_csr(12'h341, d);
    total++; if (d !== 32'h0000_0040) begin bad++; $display("FAIL ecall_mepc: got %h want 00000040", d); end
    read_csr(12'h342, d);
    total++; if (d !== 32'd11) begin bad++; $display("FAIL ecall_mcause: got %h want 0000000b", d); end
    read_csr(12'h300, d);
    total++; if (d !== 32'h0000_1880) begin bad++; $display("FAIL ecall_mstatus: got %h want 00001880", d); end
    read_csr(12'h340, d);
    total++; if (d !== 32'hDEAD_BEE0) begin bad++; $display("FAIL busy_ignored: got %h want deadbee0", d); end
  endtask

  task automatic test_back_to_back_mret();
    logic [31:0] d;
    redirect_ready_i = 1;
    valid_i = 1; is_mret_i = 1; #1;
    tick(); clear_inputs();
    total++; if (redirect_valid_o !== 1'b1) begin bad++; $display("FAIL mret_rv: got %b want 1", redirect_valid_o); end
    total++; if (redirect_pc_o !== 32'h0000_0040) begin bad++; $display("FAIL mret_rpc: got %h want 00000040", redirect_pc_o); end
    tick();
    redirect_ready_i = 0;
    total++; if (redirect_valid_o !== 1'b0) begin bad++; $display("FAIL mret_dwell: got %b want 0", redirect_valid_o); end
    read_csr(12'h300, d);
    total++; if (d !== 32'h0000_1888) begin bad++; $display("FAIL mret_mstatus: got %h want 00001888", d); end
  endtask

  task automatic test_illegal();
    logic [31:0] d, r0;
    read_csr(12'hB02, r0);
`ifndef CSR_COUNTERS_EN
    total++; if (r0 !== 32'h0) begin bad++; $display("FAIL nocnt_instret: got %h want 0", r0); end
`endif
    drive_csr(OP_RW, 12'hC00, 1'b0, 5'd1, 32'h5, 32'h0000_0080);
    total++; if (csr_rdata_o !== 32'h0) begin bad++; $display("FAIL ro_rdata: got %h want 0", csr_rdata_o); end
    tick(); clear_inputs();
    total++; if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'h0000_0100) begin bad++; $display("FAIL ro_trap: got rv=%b pc=%h want 1/00000100", redirect_valid_o, redirect_pc_o); end
    accept_redirect();
    read_csr(12'hB02, d);
`ifdef CSR_COUNTERS_EN
    total++; if (d !== r0 + 32'd1) begin bad++; $display("FAIL ro_instret: got %h want %h", d, r0 + 32'd1); end
`else
    total++; if (d !== 32'h0) begin bad++; $display("FAIL ro_instret: got %h want 0", d); end
`endif
    read_csr(12'h342, d);
    total++; if (d !== 32'd2) begin bad++; $display("FAIL ro_mcause: got %h want 00000002", d); end
    read_csr(12'h341, d);
    total++; if (d !== 32'h0000_0080) begin bad++; $display("FAIL ro_mepc: got %h want 00000080", d); end
    read_csr(12'h300, d);
    total++; if (d !== 32'h0000_1880) begin bad++; $display("FAIL ro_mstatus: got %h want 00001880", d); end
    drive_csr(OP_RS, 12'h123, 1'b0, 5'd0, 32'h0, 32'h0000_0084);
    tick(); clear_inputs();
    total++; if (redirect_valid_o !== 1'b1) begin bad++; $display("FAIL unmapped_trap: got %b want 1", redirect_valid_o); end
    accept_redirect();
    read_csr(12'h341, d);
    total++; if (d !== 32'h0000_0084) begin bad++; $display("FAIL unmapped_mepc: got %h want 00000084", d); end
    drive_csr(OP_RS, 12'hC00, 1'b0, 5'd0, 32'hFFFF_FFFF, 32'h0000_0088);
`ifndef CSR_COUNTERS_EN
    total++; if (csr_rdata_o !== 32'h0) begin bad++; $display("FAIL cycle_read: got %h want 0", csr_rdata_o); end
`endif
    tick(); clear_inputs();
    total++; if (redirect_valid_o !== 1'b0) begin bad++; $display("FAIL ro_read_legal: got rv=%b want 0", redirect_valid_o); end
  endtask

  task automatic test_counters();
    logic [31:0] d;
`ifdef CSR_COUNTERS_EN
    read_csr(12'hB80, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL mcycleh_pre: got %h want 0", d); end
    drive_csr(OP_RW, 12'hB00, 1'b0, 5'd1, 32'hFFFF_FFFF, 32'h0);
    tick(); clear_inputs();
    total++; if (redirect_valid_o !== 1'b0) begin bad++; $display("FAIL mcycle_write_trap: got %b want 0", redirect_valid_o); end
    tick();
    read_csr(12'hB00, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL mcycle_wrap: got %h want 0", d); end
    read_csr(12'hB80, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL mcycleh_carry: got %h want 1", d); end
`else
    drive_csr(OP_RW, 12'hB00, 1'b0, 5'd1, 32'hFFFF_FFFF, 32'h0);
    total++; if (csr_rdata_o !== 32'h0) begin bad++; $display("FAIL nocnt_rdata: got %h want 0", csr_rdata_o); end
    tick(); clear_inputs();
    total++; if (redirect_valid_o !== 1'b0) begin bad++; $display("FAIL nocnt_write_legal: got %b want 0", redirect_valid_o); end
    tick();
    read_csr(12'hB00, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL nocnt_mcycle: got %h want 0", d); end
    drive_csr(OP_RW, 12'hC80, 1'b0, 5'd1, 32'h1, 32'h0);
    tick(); clear_inputs();
    total++; if (redirect_valid_o !== 1'b1) begin bad++; $display("FAIL nocnt_ro_trap: got %b want 1", redirect_valid_o); end
    accept_redirect();
`endif
  endtask

  task automatic test_reset_in_redirect();
    logic [31:0] d;
    valid_i = 1; is_ecall_i = 1; pc_i = 32'h0000_0044; #1;
    tick(); clear_inputs();
    total++; if (redirect_valid_o !== 1'b1) begin bad++; $display("FAIL rst_pre_rv: got %b want 1", redirect_valid_o); end
    rst_i = 1;
    tick();
    rst_i = 0;
    total++; if (redirect_valid_o !== 1'b0 || busy_o !== 1'b0) begin bad++; $display("FAIL rst_redirect: got rv=%b busy=%b want 0/0", redirect_valid_o, busy_o); end
    total++; if (redirect_pc_o !== 32'h0) begin bad++; $display("FAIL rst_rpc: got %h want 0", redirect_pc_o); end
    read_csr(12'h300, d);
    total++; if (d !== 32'h0000_1800) begin bad++; $display("FAIL rst_mstatus: got %h want 00001800", d); end
    read_csr(12'h341, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_mepc: got %h want 0", d); end
  endtask

  initial begin
    test_reset();
    test_csr_ops();
    test_masks();
    test_ecall();
    test_back_to_back_mret();
    test_illegal();
    test_counters();
    test_reset_in_redirect();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
